// File: rtl/mac_learn_table_if.sv
// Request/response bus of the MAC learning table.
// The master issues lookups and consumes forwarding results; the slave is the table.
interface mac_learn_table_if #(
    parameter int NUM_PORTS = 4
);
    localparam int PW = $clog2(NUM_PORTS);

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [47:0]          req_src_mac_i;
    logic [47:0]          req_dst_mac_i;
    logic [PW-1:0]        req_port_i;
    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic [NUM_PORTS-1:0] resp_port_mask_o;
    logic                 resp_flood_o;

    modport master (
        output req_valid_i, req_src_mac_i, req_dst_mac_i, req_port_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_port_mask_o, resp_flood_o
    );

    modport slave (
        input  req_valid_i, req_src_mac_i, req_dst_mac_i, req_port_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_port_mask_o, resp_flood_o
    );
endinterface

// File: rtl/mac_learn_table.sv
// Source-MAC learning / destination-MAC forwarding table.
// Fully associative, searched one entry per cycle; round-robin replacement
// when full; periodic aging removes stations not seen since the previous sweep.
module mac_learn_table #(
    parameter int NUM_PORTS   = 4,
    parameter int NUM_ENTRIES = 16,
    parameter int AGE_PERIOD  = 1_000_000
) (
    input  logic                         switch_clk,
    input  logic                         switch_rst_n,
    mac_learn_table_if.slave             bus,
    input  logic                         flush_i,
    output logic [$clog2(NUM_ENTRIES):0] entry_count_o
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int EW = $clog2(NUM_ENTRIES);
    localparam int AW = $clog2(AGE_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_UPDATE, S_RESP} state_t;

    state_t                 r_state;
    logic [EW-1:0]          r_idx;
    logic [EW-1:0]          r_victim;
    logic [47:0]            r_src_mac;
    logic [47:0]            r_dst_mac;
    logic [PW-1:0]          r_in_port;
    logic                   r_src_hit;
    logic                   r_dst_hit;
    logic                   r_free_found;
    logic [EW-1:0]          r_src_idx;
    logic [EW-1:0]          r_dst_idx;
    logic [EW-1:0]          r_free_idx;
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [NUM_ENTRIES-1:0] r_hit;
    logic [47:0]            r_mac_tab  [NUM_ENTRIES];
    logic [PW-1:0]          r_port_tab [NUM_ENTRIES];
    logic                   r_req_ready;
    logic                   r_resp_valid;
    logic                   r_resp_flood;
    logic [NUM_PORTS-1:0]   r_resp_mask;
    logic                   r_sweep_pending;
    logic [AW-1:0]          r_age_cnt;
    logic [EW:0]            r_count;

    logic                   w_age_wrap;
    logic                   w_accept;
    logic                   w_sweep_go;
    logic                   w_resp_done;
    logic                   w_pend_next;
    logic                   w_idle_next;
    logic                   w_cur_valid;
    logic                   w_cur_src_match;
    logic                   w_cur_dst_match;
    logic                   w_learn;
    logic [EW-1:0]          w_wr_idx;
    logic [PW-1:0]          w_dst_port;
    logic [NUM_PORTS-1:0]   w_ingress_oh;
    logic [NUM_PORTS-1:0]   w_dst_oh;

    function automatic logic [EW:0] count_ones(input logic [NUM_ENTRIES-1:0] v);
        logic [EW:0] c;
        c = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            c = c + {{EW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign w_age_wrap  = (r_age_cnt == AW'(AGE_PERIOD - 1));
    // r_req_ready is only ever high in IDLE with no sweep pending
    assign w_accept    = bus.req_valid_i && r_req_ready && !flush_i;
    assign w_sweep_go  = (r_state == S_IDLE) && r_sweep_pending && !flush_i;
    assign w_resp_done = (r_state == S_RESP) && bus.resp_ready_i;
    assign w_pend_next = w_age_wrap || (r_sweep_pending && !w_sweep_go);
    assign w_idle_next = flush_i || ((r_state == S_IDLE) && !w_accept) || w_resp_done;

    assign w_cur_valid     = r_valid[r_idx];
    assign w_cur_src_match = w_cur_valid && (r_mac_tab[r_idx] == r_src_mac);
    assign w_cur_dst_match = w_cur_valid && (r_mac_tab[r_idx] == r_dst_mac);

    // Learning target: existing station first, then a free slot, then the RR victim
    assign w_learn  = (r_state == S_UPDATE) && !flush_i && !r_src_mac[40];
    assign w_wr_idx = r_src_hit ? r_src_idx : (r_free_found ? r_free_idx : r_victim);

    assign w_dst_port   = r_port_tab[r_dst_idx];
    assign w_ingress_oh = NUM_PORTS'(1) << r_in_port;
    assign w_dst_oh     = NUM_PORTS'(1) << w_dst_port;

    // Free-running aging timebase; unaffected by flush
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            r_age_cnt <= '0;
        end else begin
            r_age_cnt <= w_age_wrap ? '0 : r_age_cnt + 1'b1;
        end
    end

    // Entry payload storage written during UPDATE
    // NOTE: MAC/port storage has no reset; the valid bits alone decide whether an entry is meaningful.
    always_ff @(posedge switch_clk) begin
        if (w_learn) begin
            r_mac_tab[w_wr_idx]  <= r_src_mac;
            r_port_tab[w_wr_idx] <= r_in_port;
        end
    end

    // Request FSM, valid/hit bookkeeping, aging sweep, flush and registered outputs
    // NOTE: every state element here uses non-blocking assignment so all reads see pre-edge values.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_victim        <= '0;
            r_src_mac       <= '0;
            r_dst_mac       <= '0;
            r_in_port       <= '0;
            r_src_hit       <= 1'b0;
            r_dst_hit       <= 1'b0;
            r_free_found    <= 1'b0;
            r_src_idx       <= '0;
            r_dst_idx       <= '0;
            r_free_idx      <= '0;
            r_valid         <= '0;
            r_hit           <= '0;
            r_req_ready     <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_flood    <= 1'b0;
            r_resp_mask     <= '0;
            r_sweep_pending <= 1'b0;
            r_count         <= '0;
        end else begin
            r_req_ready     <= w_idle_next && !w_pend_next;
            r_sweep_pending <= w_pend_next;
            r_count         <= count_ones(r_valid);
            if (flush_i) begin
                r_valid      <= '0;
                r_hit        <= '0;
                r_state      <= S_IDLE;
                r_resp_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_sweep_pending) begin
                            r_valid <= r_valid & r_hit;
                            r_hit   <= '0;
                        end else if (w_accept) begin
                            r_src_mac    <= bus.req_src_mac_i;
                            r_dst_mac    <= bus.req_dst_mac_i;
                            r_in_port    <= bus.req_port_i;
                            r_idx        <= '0;
                            r_src_hit    <= 1'b0;
                            r_dst_hit    <= 1'b0;
                            r_free_found <= 1'b0;
                            r_state      <= S_SEARCH;
                        end
                    end
                    S_SEARCH: begin
                        if (!r_src_hit && w_cur_src_match) begin
                            r_src_hit <= 1'b1;
                            r_src_idx <= r_idx;
                        end
                        if (!r_dst_hit && w_cur_dst_match) begin
                            r_dst_hit <= 1'b1;
                            r_dst_idx <= r_idx;
                        end
                        if (!r_free_found && !w_cur_valid) begin
                            r_free_found <= 1'b1;
                            r_free_idx   <= r_idx;
                        end
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == EW'(NUM_ENTRIES - 1)) begin
                            r_state <= S_UPDATE;
                        end
                    end
                    S_UPDATE: begin
                        if (w_learn) begin
                            r_valid[w_wr_idx] <= 1'b1;
                            r_hit[w_wr_idx]   <= 1'b1;
                            if (!r_src_hit && !r_free_found) begin
                                r_victim <= (r_victim == EW'(NUM_ENTRIES - 1)) ? '0 : r_victim + 1'b1;
                            end
                        end
                        if (r_dst_mac[40]) begin
                            r_resp_mask  <= ~w_ingress_oh;
                            r_resp_flood <= 1'b1;
                        end else if (r_dst_hit) begin
                            r_hit[r_dst_idx] <= 1'b1;
                            r_resp_mask      <= (w_dst_port == r_in_port) ? '0 : w_dst_oh;
                            r_resp_flood     <= 1'b0;
                        end else begin
                            r_resp_mask  <= ~w_ingress_oh;
                            r_resp_flood <= 1'b1;
                        end
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                    S_RESP: begin
                        if (bus.resp_ready_i) begin
                            r_resp_valid <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready_o      = r_req_ready;
    assign bus.resp_valid_o     = r_resp_valid;
    assign bus.resp_port_mask_o = r_resp_mask;
    assign bus.resp_flood_o     = r_resp_flood;
    assign entry_count_o        = r_count;

endmodule
